// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard stall/flush controller: RUN/HOLD2 FSM with combinational enables.
// Optional saturating performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_stall_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        stall_twice,
    input  logic        BranchTK_ID,
    input  logic        ext_hold,
    input  logic        perf_clr,
    output logic        PC_En,
    output logic        IF2ID_En,
    output logic        IF2ID_Flush,
    output logic        ID2EXE_En,
    output logic        ID2EXE_Bubble,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        HOLD2 = 1'b1
    } state_t;

    state_t state, state_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    always_comb begin
        state_nxt     = state;
        PC_En         = 1'b1;
        IF2ID_En      = 1'b1;
        IF2ID_Flush   = 1'b0;
        ID2EXE_En     = 1'b1;
        ID2EXE_Bubble = 1'b0;

        if (!rst_n) begin
            PC_En         = 1'b0;
            IF2ID_En      = 1'b0;
            IF2ID_Flush   = 1'b1;
            ID2EXE_Bubble = 1'b1;
            state_nxt     = RUN;
        end else if (ext_hold) begin
            PC_En     = 1'b0;
            IF2ID_En  = 1'b0;
            ID2EXE_En = 1'b0;
        end else if (state == HOLD2) begin
            PC_En         = 1'b0;
            IF2ID_En      = 1'b0;
            ID2EXE_Bubble = 1'b1;
            state_nxt     = RUN;
        end else if (stall_twice) begin
            PC_En         = 1'b0;
            IF2ID_En      = 1'b0;
            ID2EXE_Bubble = 1'b1;
            state_nxt     = HOLD2;
        end else if (stall) begin
            PC_En         = 1'b0;
            IF2ID_En      = 1'b0;
            ID2EXE_Bubble = 1'b1;
        end else if (BranchTK_ID) begin
            // Flush only when no stall is active: the branch operands are valid this cycle.
            IF2ID_Flush = 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // A frozen pipeline leaves the counters untouched, including a pending clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (!ext_hold) begin
            if (perf_clr) begin
                stall_q <= '0;
                flush_q <= '0;
            end else begin
                if (ID2EXE_Bubble && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
                if (IF2ID_Flush && (flush_q != 16'hFFFF))   flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cycles    = 16'h0000;
    assign flush_count     = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: driver pushes model predictions, monitor checks them.
// Counter expectations follow PIPE_PERF_CNT_EN exactly as the design build does.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        stall_twice = 1'b0;
    logic        BranchTK_ID = 1'b0;
    logic        ext_hold = 1'b0;
    logic        perf_clr = 1'b0;
    logic        PC_En, IF2ID_En, IF2ID_Flush, ID2EXE_En, ID2EXE_Bubble;
    logic [15:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .stall_twice   (stall_twice),
        .BranchTK_ID   (BranchTK_ID),
        .ext_hold      (ext_hold),
        .perf_clr      (perf_clr),
        .PC_En         (PC_En),
        .IF2ID_En      (IF2ID_En),
        .IF2ID_Flush   (IF2ID_Flush),
        .ID2EXE_En     (ID2EXE_En),
        .ID2EXE_Bubble (ID2EXE_Bubble),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    // Control vector order: {PC_En, IF2ID_En, IF2ID_Flush, ID2EXE_En, ID2EXE_Bubble}
    localparam logic [4:0] CTL_RESET  = 5'b00111;
    localparam logic [4:0] CTL_FROZEN = 5'b00000;
    localparam logic [4:0] CTL_BUBBLE = 5'b00011;
    localparam logic [4:0] CTL_FLUSH  = 5'b11110;
    localparam logic [4:0] CTL_NORMAL = 5'b11010;

    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: number of bubbles still owed plus plain integer counters.
    int   owed_bubbles = 0;
    int   m_sc = 0;
    int   m_fc = 0;

    task automatic step(input logic r, input logic s, input logic s2, input logic b,
                        input logic h, input logic c, input string tag);
        exp_t e;
        rst_n = r; stall = s; stall_twice = s2; BranchTK_ID = b; ext_hold = h; perf_clr = c;
        e.tag = tag;
        e.sc  = 16'(m_sc);
        e.fc  = 16'(m_fc);
        if (!r) begin
            e.ctl = CTL_RESET;
            owed_bubbles = 0;
        end else if (h) begin
            e.ctl = CTL_FROZEN;
        end else if (owed_bubbles > 0) begin
            e.ctl = CTL_BUBBLE;
            owed_bubbles = owed_bubbles - 1;
        end else if (s2) begin
            e.ctl = CTL_BUBBLE;
            owed_bubbles = 1;
        end else if (s) begin
            e.ctl = CTL_BUBBLE;
        end else if (b) begin
            e.ctl = CTL_FLUSH;
        end else begin
            e.ctl = CTL_NORMAL;
        end
`ifdef PIPE_PERF_CNT_EN
        if (!r) begin
            m_sc = 0; m_fc = 0;
        end else if (!h) begin
            if (c) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (e.ctl == CTL_BUBBLE) m_sc = (m_sc >= 65535) ? 65535 : m_sc + 1;
                if (e.ctl == CTL_FLUSH)  m_fc = (m_fc >= 65535) ? 65535 : m_fc + 1;
            end
        end
`endif
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, well away from the rising edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, "/ctl"}, {11'd0, PC_En, IF2ID_En, IF2ID_Flush, ID2EXE_En, ID2EXE_Bubble},
                  {11'd0, e.ctl});
            check({e.tag, "/stall_cycles"}, stall_cycles, e.sc);
            check({e.tag, "/flush_count"}, flush_count, e.fc);
        end
    end

    initial begin
        @(posedge clk);
        #1;
        // Reset and idle
        repeat (2) step(0, 0, 0, 0, 0, 0, "reset");
        repeat (2) step(1, 0, 0, 0, 0, 0, "idle");
        // Single-cycle stall, then back-to-back stalls
        step(1, 1, 0, 0, 0, 0, "stall1");
        step(1, 0, 0, 0, 0, 0, "after_stall1");
        repeat (3) step(1, 1, 0, 1, 0, 0, "stall_b2b");
        // stall_twice with branch: two bubbles, no flush; then the branch flushes
        step(1, 0, 1, 1, 0, 0, "st2_br_a");
        step(1, 0, 0, 1, 0, 0, "st2_br_b");
        step(1, 0, 0, 1, 0, 0, "branch_flush");
        step(1, 0, 0, 0, 0, 0, "after_flush");
        // stall_twice held under ext_hold: frozen, no state change, then release
        repeat (3) step(1, 0, 1, 1, 1, 1, "hold_st2");
        step(1, 0, 0, 0, 0, 0, "hold_release");
        // HOLD2 entered then frozen: the owed bubble survives the hold
        step(1, 0, 1, 0, 0, 0, "st2_then_hold");
        step(1, 0, 0, 1, 1, 0, "hold_in_hold2");
        step(1, 0, 0, 1, 0, 0, "hold2_after_hold");
        step(1, 0, 0, 1, 0, 0, "flush_after_hold2");
        // Reset in the HOLD2 cycle discards the second bubble
        step(1, 0, 1, 0, 0, 0, "st2_before_rst");
        step(0, 1, 1, 1, 0, 0, "rst_in_hold2");
        step(1, 0, 0, 0, 0, 0, "run_after_rst");
        // perf_clr alone and with a branch
        step(1, 1, 0, 0, 0, 0, "stall_pre_clr");
        step(1, 0, 0, 1, 0, 1, "clr_with_branch");
        step(1, 0, 0, 0, 0, 0, "after_clr");
`ifdef PIPE_PERF_CNT_EN
        // Saturation of stall_cycles, then clear wins over an increment
        repeat (65540) step(1, 1, 0, 0, 0, 0, "sat");
        step(1, 1, 0, 0, 0, 1, "clr_with_stall");
        step(1, 0, 0, 0, 0, 0, "after_sat_clr");
`endif
        // Randomized mix of all requests
        for (int i = 0; i < 3000; i++) begin
            logic r, s, s2, b, h, c;
            r  = ($urandom_range(0, 99) >= 3);
            s  = ($urandom_range(0, 99) < 25);
            s2 = ($urandom_range(0, 99) < 15);
            b  = ($urandom_range(0, 99) < 35);
            h  = ($urandom_range(0, 99) < 15);
            c  = ($urandom_range(0, 99) < 3);
            step(r, s, s2, b, h, c, "random");
        end
        step(1, 0, 0, 0, 0, 0, "final_idle");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d expected entries left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; ports in the lines below SHALL appear clock and reset first.
REQ-002 clk  input  1  pipeline clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 stall  input  1  single-cycle load-use stall request from hazard detection.
REQ-005 stall_twice  input  1  two-cycle stall request (load feeding a taken branch in ID).
REQ-006 BranchTK_ID  input  1  branch/jump taken, resolved in ID.
REQ-007 ext_hold  input  1  whole-pipeline freeze (memory not ready).
REQ-008 perf_clr  input  1  synchronous clear of the performance counters.
REQ-009 PC_En  output  1  PC write enable.
REQ-010 IF2ID_En  output  1  IF/ID register write enable.
REQ-011 IF2ID_Flush  output  1  IF/ID register loads a NOP.
REQ-012 ID2EXE_En  output  1  ID/EXE register write enable.
REQ-013 ID2EXE_Bubble  output  1  ID/EXE register loads a bubble (control signals zeroed).
REQ-014 stall_cycles  output  16  saturating count of hazard-stall cycles.
REQ-015 flush_count  output  16  saturating count of flush cycles.

Function
REQ-016 The FSM SHALL have states RUN and HOLD2; the control outputs SHALL be combinational from state and inputs, so a stall takes effect in the cycle it is requested.
REQ-017 Priority SHALL be: reset > ext_hold > HOLD2 > stall_twice > stall > BranchTK_ID > normal.
REQ-018 ext_hold=1 SHALL force PC_En=0, IF2ID_En=0, ID2EXE_En=0, IF2ID_Flush=0, ID2EXE_Bubble=0; the FSM state and counters SHALL NOT change.
REQ-019 In HOLD2 without ext_hold, outputs SHALL be PC_En=0, IF2ID_En=0, ID2EXE_En=1, ID2EXE_Bubble=1, IF2ID_Flush=0; stall, stall_twice and BranchTK_ID SHALL be ignored; next state SHALL be RUN.
REQ-020 In RUN with stall_twice=1, outputs SHALL equal those of REQ-019 and next state SHALL be HOLD2, giving exactly two bubble cycles.
REQ-021 In RUN with stall=1 and stall_twice=0, outputs SHALL equal those of REQ-019 and the state SHALL remain RUN; back-to-back stall requests SHALL each yield one bubble cycle.
REQ-022 In RUN with no stall and BranchTK_ID=1, outputs SHALL be PC_En=1, IF2ID_En=1, IF2ID_Flush=1, ID2EXE_En=1, ID2EXE_Bubble=0.
REQ-023 IF2ID_Flush SHALL NOT be asserted in any cycle in which a stall or ext_hold is active, because the branch decision uses stale operands.
REQ-024 In RUN with no request, all enables SHALL be 1 and IF2ID_Flush=ID2EXE_Bubble=0.
REQ-025 stall_cycles SHALL increment by 1 in every cycle with ID2EXE_Bubble=1 and saturate at 16'hFFFF.
REQ-026 flush_count SHALL increment by 1 in every cycle with IF2ID_Flush=1 and saturate at 16'hFFFF.
REQ-027 perf_clr=1 SHALL clear both counters to 0 on the next edge, with priority over an increment in the same cycle.

Reset
REQ-028 While rst_n=0, outputs SHALL be PC_En=0, IF2ID_En=0, IF2ID_Flush=1, ID2EXE_En=1, ID2EXE_Bubble=1.
REQ-029 A rising edge with rst_n=0 SHALL set the state to RUN and both counters to 0, including when the FSM is in HOLD2 (the pending second bubble is discarded).

Configuration
REQ-030 Macro PIPE_PERF_CNT_EN: when defined, REQ-025 to REQ-027 SHALL be implemented.
REQ-031 When PIPE_PERF_CNT_EN is undefined, stall_cycles and flush_count SHALL be driven constant 0, perf_clr SHALL be ignored, no counter flops SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then idle RUN -> all enables 1, flush=bubble=0, counters 0.
REQ-033 stall=1 for 1 cycle -> exactly 1 cycle with PC_En=0 and IF2ID_En=0, ID2EXE_Bubble=1; stall_cycles=1.
REQ-034 stall_twice=1 and BranchTK_ID=1 for 1 cycle -> 2 bubble cycles, IF2ID_Flush=0 in both; BranchTK_ID=1 in the third cycle -> IF2ID_Flush=1, flush_count=1.
REQ-035 stall_twice=1 with ext_hold=1 held for 3 cycles, then ext_hold=0 -> 3 frozen cycles (all enables 0), then bubble cycles only if requested; state unchanged during the hold.
REQ-036 rst_n=0 in the HOLD2 cycle -> next cycle RUN, no second bubble; counters 0.
REQ-037 Force stall for 65540 cycles -> stall_cycles=16'hFFFF; perf_clr together with stall -> 0 next cycle; with the macro undefined -> counters always 0.
